// File: rtl/round_ctrl_pipelined.sv
// Round/stage sequencer for round-based masked ciphers with a pipelined S-box layer.
// Define ROUND_CTRL_DECRYPT_EN to add the decrypt port and downward round counting.
module round_ctrl_pipelined #(
    parameter int SBOX_STAGES = 4,
    parameter int NUM_ROUNDS  = 16,
    parameter int ROUND_W     = 4,
    parameter int STAGE_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
`ifdef ROUND_CTRL_DECRYPT_EN
    input  logic               decrypt,
`endif
    output logic [ROUND_W-1:0] round,
    output logic [STAGE_W-1:0] stage,
    output logic               roundStart_Select,
    output logic               round_tick,
    output logic               last_round,
    output logic               EN,
    output logic               busy,
    output logic               done,
    output logic [1:0]         state_dbg
);

    // Handshake: start is only taken in IDLE or DONE; busy covers LOAD+RUN;
    // done holds in DONE until the next start or an abort. abort beats start.

    if (SBOX_STAGES < 1 || SBOX_STAGES > 16) begin : g_bad_stages
        $error("round_ctrl_pipelined: SBOX_STAGES must be in 1..16");
    end
    if (NUM_ROUNDS < 1 || longint'(NUM_ROUNDS) > (longint'(1) << ROUND_W)) begin : g_bad_rounds
        $error("round_ctrl_pipelined: NUM_ROUNDS must be in 1..2**ROUND_W");
    end
    if ((longint'(1) << STAGE_W) < longint'(SBOX_STAGES)) begin : g_bad_stage_w
        $error("round_ctrl_pipelined: STAGE_W too narrow for SBOX_STAGES");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(NUM_ROUNDS - 1);
    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(SBOX_STAGES - 1);

    state_t             state_q;
    state_t             state_d;
    logic [ROUND_W-1:0] round_q;
    logic [STAGE_W-1:0] stage_q;
    logic               dir_q;
    logic [ROUND_W-1:0] load_round;
    logic               stage_end;
    logic               round_final;
    logic               take_start;

    assign take_start = start && !abort && (state_q == S_IDLE || state_q == S_DONE);

`ifdef ROUND_CTRL_DECRYPT_EN
    // Direction is captured with the start request and held for the operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dir_q <= 1'b0;
        end else if (abort) begin
            dir_q <= 1'b0;
        end else if (take_start) begin
            dir_q <= decrypt;
        end
    end
    assign load_round = decrypt ? ROUND_LAST : '0;
`else
    assign dir_q      = 1'b0;
    assign load_round = '0;
`endif

    assign stage_end   = (stage_q == STAGE_LAST);
    assign round_final = dir_q ? (round_q == '0) : (round_q == ROUND_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start) state_d = S_LOAD;
                S_LOAD:  state_d = S_RUN;
                S_RUN:   if (stage_end && round_final) state_d = S_DONE;
                S_DONE:  if (start) state_d = S_LOAD;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Counters stay frozen on the final stage so DONE shows where the run ended.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            round_q <= '0;
            stage_q <= '0;
        end else if (abort) begin
            round_q <= '0;
            stage_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        round_q <= load_round;
                        stage_q <= '0;
                    end
                end
                S_RUN: begin
                    if (stage_end) begin
                        if (!round_final) begin
                            stage_q <= '0;
                            round_q <= dir_q ? round_q - ROUND_W'(1) : round_q + ROUND_W'(1);
                        end
                    end else begin
                        stage_q <= stage_q + STAGE_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        roundStart_Select = 1'b0;
        round_tick        = 1'b0;
        last_round        = 1'b0;
        EN                = 1'b0;
        busy              = 1'b0;
        done              = 1'b0;
        case (state_q)
            S_LOAD: begin
                roundStart_Select = 1'b1;
                EN                = 1'b1;
                busy              = 1'b1;
            end
            S_RUN: begin
                EN         = 1'b1;
                busy       = 1'b1;
                round_tick = stage_end;
                last_round = round_final;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign round     = round_q;
    assign stage     = stage_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_round_ctrl_pipelined.sv
// Directed bench for round_ctrl_pipelined: default 4x16 instance plus a 1-stage, 12-round instance.
// Decrypt vectors are compiled in when ROUND_CTRL_DECRYPT_EN is defined.
module tb_round_ctrl_pipelined;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start, abort;
    logic start_s, abort_s;
`ifdef ROUND_CTRL_DECRYPT_EN
    logic decrypt, decrypt_s;
`endif

    logic [3:0] round;
    logic [3:0] stage;
    logic       rss, tick, last, en, busy, done;
    logic [1:0] dbg;

    logic [3:0] round_s;
    logic [0:0] stage_s;
    logic       rss_s, tick_s, last_s, en_s, busy_s, done_s;
    logic [1:0] dbg_s;

    round_ctrl_pipelined u_dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
`ifdef ROUND_CTRL_DECRYPT_EN
        .decrypt(decrypt),
`endif
        .round(round), .stage(stage), .roundStart_Select(rss), .round_tick(tick),
        .last_round(last), .EN(en), .busy(busy), .done(done), .state_dbg(dbg)
    );

    round_ctrl_pipelined #(.SBOX_STAGES(1), .NUM_ROUNDS(12), .ROUND_W(4), .STAGE_W(1)) u_small (
        .clk(clk), .reset(reset), .start(start_s), .abort(abort_s),
`ifdef ROUND_CTRL_DECRYPT_EN
        .decrypt(decrypt_s),
`endif
        .round(round_s), .stage(stage_s), .roundStart_Select(rss_s), .round_tick(tick_s),
        .last_round(last_s), .EN(en_s), .busy(busy_s), .done(done_s), .state_dbg(dbg_s)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] pack(input int r, input int s, input logic t, input logic l);
        return (32'(r) << 8) | (32'(s) << 4) | (32'(t) << 1) | 32'(l);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_round"}, 32'(round), 0);
        check({tag, "_stage"}, 32'(stage), 0);
        check({tag, "_ctl"}, {26'd0, rss, tick, last, en, busy, done}, 0);
    endtask

    // Starts a run from IDLE/DONE and checks LOAD, every RUN cycle and DONE entry.
    task automatic run_main(input bit dec, input bit hold_start, input string tag);
        int r;
        int s;
        start = 1'b1;
`ifdef ROUND_CTRL_DECRYPT_EN
        decrypt = dec;
`endif
        step();
        if (!hold_start) start = 1'b0;
`ifdef ROUND_CTRL_DECRYPT_EN
        decrypt = ~dec;
`endif
        check({tag, "_load_rss"}, 32'(rss), 1);
        check({tag, "_load_en_busy_done"}, {29'd0, en, busy, done}, 32'b110);
        check({tag, "_load_rs"}, pack(round, stage, 1'b0, 1'b0), pack(dec ? 15 : 0, 0, 1'b0, 1'b0));
        for (int c = 0; c < 64; c++) begin
            r = dec ? 15 - c / 4 : c / 4;
            s = c % 4;
            exp_q.push_back(pack(r, s, s == 3, r == (dec ? 0 : 15)));
        end
        for (int c = 0; c < 64; c++) begin
            step();
            check($sformatf("%s_run%0d_rs", tag, c), pack(round, stage, tick, last), exp_q.pop_front());
            check($sformatf("%s_run%0d_ctl", tag, c), {28'd0, rss, en, busy, done}, 32'b0110);
        end
        step();
        check({tag, "_done_ctl"}, {26'd0, rss, tick, last, en, busy, done}, 32'b000001);
        check({tag, "_done_rs"}, pack(round, stage, 1'b0, 1'b0), pack(dec ? 0 : 15, 3, 1'b0, 1'b0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        start_s = 1'b0; abort_s = 1'b0;
`ifdef ROUND_CTRL_DECRYPT_EN
        decrypt = 1'b0; decrypt_s = 1'b0;
`endif
        step();
        step();
        check_idle("rst");
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle($sformatf("idle%0d", i));
        end

        // Default encryption run, then DONE holds with counters frozen.
        run_main(1'b0, 1'b0, "enc");
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold%0d_done", i), {30'd0, en, done}, 32'b01);
            check($sformatf("hold%0d_rs", i), pack(round, stage, tick, last), pack(15, 3, 1'b0, 1'b0));
        end

        // start held high through RUN into DONE, then back-to-back second run.
        run_main(1'b0, 1'b1, "hold");
        run_main(1'b0, 1'b0, "b2b");

        // abort together with start at round 7 stage 2.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 31; i++) step();
        check("abort_pre_rs", pack(round, stage, 1'b0, 1'b0), pack(7, 2, 1'b0, 1'b0));
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        check_idle("abort");
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("abort_after%0d_busy_done", i), {30'd0, busy, done}, 0);
        end

        // Asynchronous reset in the middle of RUN.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("mid_busy", 32'(busy), 1);
        reset = 1'b0;
        #1;
        check_idle("async_rst");
        step();
        step();
        check_idle("rst_hold");
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle($sformatf("rst_rel%0d", i));
        end

        // One-stage pipeline, 12 rounds.
        start_s = 1'b1;
        step();
        start_s = 1'b0;
        check("s1_load", {27'd0, rss_s, en_s, busy_s, done_s, tick_s}, 32'b11100);
        check("s1_load_round", 32'(round_s), 0);
        for (int c = 0; c < 12; c++) begin
            step();
            check($sformatf("s1_run%0d", c), pack(round_s, stage_s, tick_s, last_s), pack(c, 0, 1'b1, c == 11));
            check($sformatf("s1_run%0d_ctl", c), {28'd0, rss_s, en_s, busy_s, done_s}, 32'b0110);
        end
        step();
        check("s1_done", {29'd0, en_s, busy_s, done_s}, 32'b001);
        check("s1_done_round", 32'(round_s), 11);
        step();
        check("s1_frozen", pack(round_s, stage_s, tick_s, done_s), pack(11, 0, 1'b0, 1'b1));

`ifdef ROUND_CTRL_DECRYPT_EN
        run_main(1'b1, 1'b0, "dec");
        run_main(1'b0, 1'b0, "enc2");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
